// File: rtl/mem_pkg.sv
// Shared memory-access definitions: control-word encodings and the sequencer state type,
// reused by the access controller and the future cache/bus arbiter.
package mem_pkg;

    localparam logic MEM_CS_ENABLE = 1'b1;
    localparam logic MEM_RD_READ   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Word accesses require the two byte-offset bits to be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Down-counter that flags expiry after LOAD run cycles following a clear.
module wait_timer #(
    parameter int unsigned LOAD = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (LOAD < 1) ? 1 : $clog2(LOAD + 1);

    logic [CNT_W-1:0] count;

    // expired is registered alongside the count so it is valid in the cycle count reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= CNT_W'(LOAD);
            expired <= (LOAD == 0);
        end else if (run && (count != '0)) begin
            count   <= count - CNT_W'(1);
            expired <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between decoded memory controls and a req/ack data-memory bus;
// stalls the pipeline while a single access is outstanding, with a bounded ack wait.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              mem_cs,
    input  logic              mem_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    mem_state_t state;
    logic       go;
    logic       read;
    logic       aligned;
    logic       start;
    logic       expired;

    assign go      = issue && (mem_cs == MEM_CS_ENABLE);
    assign read    = (mem_rd == MEM_RD_READ);
    assign aligned = word_aligned(addr[1:0]);
    assign start   = (state == IDLE) && go && aligned;

    // Pipeline is released in DONE so results and the next instruction line up.
    assign stall = start || (state == BUSY);

    wait_timer #(
        .LOAD(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .run    ((state == BUSY) && !bus_ack),
        .expired(expired)
    );

    // Sequencer with registered bus and result outputs; ack beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (aligned) begin
                            bus_addr  <= addr;
                            bus_wdata <= wdata;
                            bus_we    <= !read;
                            bus_req   <= 1'b1;
                            state     <= BUSY;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (!bus_we) begin
                            rdata       <= bus_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end else if (expired) begin
                        bus_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard of expected completion pulses.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue = 1'b0;
    logic        mem_cs = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .mem_cs     (mem_cs),
        .mem_rd     (mem_rd),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every rdata_valid/err pulse must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (rdata_valid || err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rdata_valid, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_valid", 32'(rdata_valid), 32'(!e.is_err));
                chk("pulse_err", 32'(err), 32'(e.is_err));
                chk("pulse_rdata", rdata, e.data);
            end
        end
    end

    // One access: go in the first cycle, ack on BUSY cycle ack_at (-1 = never); junk inputs afterwards.
    task automatic txn(input string tag, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] ack_data, input int exp_stall, input int exp_req);
        int stall_cnt = 0;
        int req_cnt = 0;
        bit seen = 0;
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            issue  = 1'b1;
            mem_cs = MEM_CS_ENABLE;
            if (k == 0) begin
                mem_rd = rd;
                addr   = a;
                wdata  = wd;
            end else begin
                mem_rd = !rd;
                addr   = a + 32'h40;
                wdata  = ~wd;
            end
            bus_ack   = bus_req && (req_cnt == ack_at);
            bus_rdata = bus_ack ? ack_data : 32'hBAD0_0000 + 32'(k);
            #1;
            if (stall) stall_cnt++;
            if (bus_req) begin
                seen = 1;
                req_cnt++;
                chk({tag, "_we"}, 32'(bus_we), 32'(!rd));
                chk({tag, "_addr"}, bus_addr, a);
                chk({tag, "_wdata"}, bus_wdata, wd);
            end else if (seen) begin
                done = 1;
            end
        end
        issue   = 1'b0;
        bus_ack = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_valid", 32'(rdata_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        #21 rst_n = 1'b1;

        // Aligned load, ack in first BUSY cycle
        sb.push_back('{is_err: 0, data: 32'hDEAD_BEEF});
        txn("load10", 1'b1, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 2, 1);
        last_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        chk("load10_rdata_hold", rdata, last_rdata);

        // Store with ack delayed 3 cycles: no pulse expected
        txn("store20", 1'b0, 32'h0000_0020, 32'h1234_5678, 3, 32'h0, 5, 4);
        @(posedge clk); #2;
        chk("store20_rdata_hold", rdata, last_rdata);

        // Chip-select disabled: nothing happens
        issue = 1'b1; mem_cs = !MEM_CS_ENABLE; mem_rd = 1'b1; addr = 32'h0000_0040;
        #1;
        chk("cs_off_stall", 32'(stall), 32'd0);
        @(posedge clk); #2;
        chk("cs_off_req", 32'(bus_req), 32'd0);
        issue = 1'b0;

        // Misaligned load
        sb.push_back('{is_err: 1, data: last_rdata});
        @(posedge clk); #1;
        issue = 1'b1; mem_cs = MEM_CS_ENABLE; mem_rd = 1'b1; addr = 32'h0000_0013;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_req0", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        issue = 1'b0;
        #1;
        chk("mis_err_next", 32'(err), 32'd1);
        chk("mis_req1", 32'(bus_req), 32'd0);
        @(posedge clk); #2;
        chk("mis_err_once", 32'(err), 32'd0);
        chk("mis_req2", 32'(bus_req), 32'd0);

        // Timeout with no ack, then ack on the expiry cycle
        sb.push_back('{is_err: 1, data: last_rdata});
        txn("tmo", 1'b1, 32'h0000_0050, 32'h0, -1, 32'h0, int'(TO) + 2, int'(TO) + 1);
        @(posedge clk); #2;
        chk("tmo_rdata_hold", rdata, last_rdata);
        sb.push_back('{is_err: 0, data: 32'h5A5A_A5A5});
        txn("ack_at_exp", 1'b1, 32'h0000_0060, 32'h0, int'(TO), 32'h5A5A_A5A5, int'(TO) + 2, int'(TO) + 1);
        last_rdata = 32'h5A5A_A5A5;

        // Reset in the second BUSY cycle, stale ack, then a fresh load
        @(posedge clk); #1;
        issue = 1'b1; mem_cs = MEM_CS_ENABLE; mem_rd = 1'b1; addr = 32'h0000_0030;
        @(posedge clk); #1;
        issue = 1'b0;
        #1;
        chk("rst_mid_busy1", 32'(bus_req), 32'd1);
        @(posedge clk); #2;
        chk("rst_mid_busy2", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_0000;
        #1;
        chk("rst_mid_req", 32'(bus_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("stale_ack_req", 32'(bus_req), 32'd0);
        chk("stale_ack_valid", 32'(rdata_valid), 32'd0);
        bus_ack = 1'b0;
        sb.push_back('{is_err: 0, data: 32'hCAFE_F00D});
        txn("reload", 1'b1, 32'h0000_0044, 32'h0, 0, 32'hCAFE_F00D, 2, 1);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
